// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the Nios II JTAG debug on-chip memory controller.
//   - FSM state type and state encodings
//   - bit positions of the fields inside the 38-bit jdo shift image
//   - default word returned for out-of-range reads
package nios2_ocimem_pkg;

  // FSM encodings are kept as plain constants so legacy tools and
  // waveform viewers see stable numeric values.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;  // waiting for JTAG or CPU work
  localparam state_t ST_JRD  = 3'd1;  // JTAG read issued to RAM
  localparam state_t ST_JCAP = 3'd2;  // JTAG read data captured
  localparam state_t ST_JWR  = 3'd3;  // JTAG write cycle
  localparam state_t ST_CRD  = 3'd4;  // CPU read completing

  // jdo field positions
  localparam int RD_BIT   = 35;
  localparam int INC_BIT  = 34;
  localparam int ADDR_LSB = 26;
  localparam int DATA_MSB = 34;
  localparam int DATA_LSB = 3;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/nios2_ocimem_ram.sv
// Single-port synchronous debug monitor RAM.
//   clk    : system clock
//   we     : write enable (caller guarantees addr is in range when set)
//   be     : byte lane enables for the write
//   addr   : word address for both read and write
//   wdata  : write data
//   q      : registered read data, valid one cycle after addr is presented
module nios2_ocimem_ram #(
  parameter int ADDR_W    = 8,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [MEM_WORDS];

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // debug monitor image must also survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_jtag_ocimem_ctrl.sv
// Debug on-chip memory controller.
// Executes JTAG address/read/write commands against the debug monitor RAM
// and shares the same RAM with the CPU through an Avalon-MM slave.
// JTAG always has priority over the CPU.
//   clk, reset_n              : system clock, synchronous active-low reset
//   jdo                       : JTAG data-out shift image
//   take_action_ocimem_a      : command/address pulse
//   take_action_ocimem_b      : write-data pulse
//   take_no_action_ocimem_a   : status-poll pulse (changes no state)
//   MonDReg                   : read result returned to the TCK side
//   monitor_ready             : MonDReg holds the result of the last read
//   monitor_error             : last JTAG command addressed out of range
//   avs_*                     : Avalon-MM slave for CPU debug-mode access
module nios2_jtag_ocimem_ctrl
  import nios2_ocimem_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] ERR_WORD  = ERR_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr_reg;
  logic              auto_inc;
  logic [ADDR_W-1:0] cpu_addr;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rd;
  logic              cmd_inc;
  logic [31:0]       jtag_wdata;
  logic              unused_jdo;

  assign cmd_addr   = jdo[ADDR_LSB +: ADDR_W];
  assign cmd_rd     = jdo[RD_BIT];
  assign cmd_inc    = jdo[INC_BIT];
  assign jtag_wdata = jdo[DATA_MSB:DATA_LSB];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  logic idle;
  logic jtag_pulse;
  logic jtag_b_go;
  logic cpu_rd_go;
  logic cpu_wr_go;

  assign idle       = (state == ST_IDLE);
  // Any JTAG pulse in IDLE, including a poll, keeps the CPU stalled that cycle.
  assign jtag_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // ocimem_a wins a collision with ocimem_b.
  assign jtag_b_go  = idle & take_action_ocimem_b & ~take_action_ocimem_a;
  assign cpu_rd_go  = idle & avs_read & ~jtag_pulse;
  // A read wins over a simultaneous write; the write stays stalled.
  assign cpu_wr_go  = idle & avs_write & ~avs_read & ~jtag_pulse;

  assign avs_waitrequest = ~reset_n | ~((state == ST_CRD) | cpu_wr_go);

  // RAM port steering
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_addr  = addr_reg;
    ram_wdata = jtag_wdata;
    if (jtag_b_go) begin
      ram_we = in_range(addr_reg);
    end else if (idle) begin
      // Present the CPU address whenever idle so a read accepted this cycle
      // has its data in CRD.
      ram_addr = avs_address;
      if (cpu_wr_go) begin
        ram_we    = avs_debugaccess & in_range(avs_address);
        ram_be    = avs_byteenable;
        ram_wdata = avs_writedata;
      end
    end
    if (!reset_n) ram_we = 1'b0;
  end

  nios2_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      addr_reg      <= '0;
      auto_inc      <= 1'b0;
      cpu_addr      <= '0;
      MonDReg       <= '0;
      avs_readdata  <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            addr_reg      <= cmd_addr;
            auto_inc      <= cmd_inc;
            monitor_error <= ~in_range(cmd_addr);
            if (cmd_rd) begin
              monitor_ready <= 1'b0;
              state         <= ST_JRD;
            end
          end else if (take_action_ocimem_b) begin
            if (!in_range(addr_reg)) monitor_error <= 1'b1;
            if (auto_inc) addr_reg <= addr_reg + ADDR_W'(1);
            state <= ST_JWR;
          end else if (cpu_rd_go) begin
            cpu_addr <= avs_address;
            state    <= ST_CRD;
          end
        end
        ST_JRD: state <= ST_JCAP;
        ST_JCAP: begin
          MonDReg       <= in_range(addr_reg) ? ram_q : ERR_WORD;
          monitor_ready <= 1'b1;
          if (auto_inc) addr_reg <= addr_reg + ADDR_W'(1);
          state <= ST_IDLE;
        end
        ST_JWR: state <= ST_IDLE;
        ST_CRD: begin
          avs_readdata <= in_range(cpu_addr) ? ram_q : ERR_WORD;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_jtag_ocimem_ctrl.sv
// Directed self-checking bench for nios2_jtag_ocimem_ctrl, built with
// MEM_WORDS=200 so addresses 200..255 are out of range.
module tb_nios2_jtag_ocimem_ctrl;

  localparam int ADDR_W    = 8;
  localparam int MEM_WORDS = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  int vectors     = 0;
  int miscompares = 0;

  nios2_jtag_ocimem_ctrl #(
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS),
    .ERR_WORD  (32'hDEADBEEF)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [7:0] addr, input logic inc, input logic rd);
    jdo           = '0;
    jdo[35]       = rd;
    jdo[34]       = inc;
    jdo[33:26]    = addr;
  endtask

  // Address command without read, then idle to honour pulse spacing.
  task automatic jtag_a(input logic [7:0] addr, input logic inc);
    set_cmd(addr, inc, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    repeat (3) tick();
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo       = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    repeat (3) tick();
  endtask

  // Read command: MonDReg/monitor_ready become valid three edges later.
  task automatic jtag_read(input string tag, input logic [7:0] addr, input logic inc,
                           input logic [31:0] exp_data, input logic exp_err);
    set_cmd(addr, inc, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    check({tag, "_ready_low"}, 32'(monitor_ready), 32'd0);
    tick();
    check({tag, "_data"}, MonDReg, exp_data);
    check({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    check({tag, "_err"}, 32'(monitor_error), 32'(exp_err));
    tick();
  endtask

  task automatic cpu_write(input string tag, input logic [7:0] addr, input logic [3:0] be,
                           input logic [31:0] data, input logic dbg);
    avs_address     = addr;
    avs_byteenable  = be;
    avs_writedata   = data;
    avs_debugaccess = dbg;
    avs_write       = 1'b1;
    #1;
    check({tag, "_wait"}, 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0;
  endtask

  // One wait cycle in IDLE, completion in CRD, data registered after CRD.
  task automatic cpu_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    avs_address = addr;
    avs_read    = 1'b1;
    #1;
    check({tag, "_wait1"}, 32'(avs_waitrequest), 32'd1);
    tick();
    check({tag, "_wait0"}, 32'(avs_waitrequest), 32'd0);
    avs_read = 1'b0;
    tick();
    check({tag, "_data"}, avs_readdata, exp);
  endtask

  initial begin
    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address             = '0;
    avs_read                = 1'b0;
    avs_write               = 1'b0;
    avs_writedata           = '0;
    avs_byteenable          = '0;
    avs_debugaccess         = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_wait", 32'(avs_waitrequest), 32'd1);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_err", 32'(monitor_error), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // JTAG write then read with auto-increment
    jtag_a(8'd5, 1'b1);
    check("a5_err", 32'(monitor_error), 32'd0);
    jtag_b(32'h12345678);
    jtag_read("jrd5", 8'd5, 1'b1, 32'h12345678, 1'b0);
    // addr_reg is now 6: the next data pulse must land there
    jtag_b(32'hCAFEF00D);
    cpu_read("crd6", 8'd6, 32'hCAFEF00D);
    check("mon_kept", MonDReg, 32'h12345678);
    check("ready_kept", 32'(monitor_ready), 32'd1);

    // Out of range
    jtag_read("jrd210", 8'd210, 1'b0, 32'hDEADBEEF, 1'b1);
    jtag_b(32'h55555555);
    check("oor_wr_err", 32'(monitor_error), 32'd1);
    cpu_read("crd210", 8'd210, 32'hDEADBEEF);
    cpu_read("crd5_intact", 8'd5, 32'h12345678);
    jtag_a(8'd0, 1'b0);
    check("err_clear", 32'(monitor_error), 32'd0);

    // Auto-increment wrap from 255 to 0
    jtag_a(8'd255, 1'b1);
    check("a255_err", 32'(monitor_error), 32'd1);
    jtag_b(32'h0BADF00D);
    jtag_b(32'h600DCAFE);
    check("wrap_err_held", 32'(monitor_error), 32'd1);
    cpu_read("crd0", 8'd0, 32'h600DCAFE);
    check("cpu_no_err_change", 32'(monitor_error), 32'd1);
    jtag_read("jrd0", 8'd0, 1'b0, 32'h600DCAFE, 1'b0);

    // CPU byte-enabled write, then a write without debug access
    jtag_a(8'd3, 1'b0);
    jtag_b(32'h11223344);
    cpu_write("cwr3", 8'd3, 4'b0011, 32'hAABBCCDD, 1'b1);
    cpu_read("crd3", 8'd3, 32'h1122CCDD);
    cpu_write("cwr3_nodbg", 8'd3, 4'b1111, 32'hFFFFFFFF, 1'b0);
    cpu_read("crd3_nodbg", 8'd3, 32'h1122CCDD);
    check("mon_after_cpu", MonDReg, 32'h600DCAFE);

    // Read and write together: read wins, write never lands
    avs_address     = 8'd3;
    avs_writedata   = 32'h0;
    avs_byteenable  = 4'hF;
    avs_debugaccess = 1'b1;
    avs_read        = 1'b1;
    avs_write       = 1'b1;
    #1;
    check("rw_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    check("rw_crd_wait", 32'(avs_waitrequest), 32'd0);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    tick();
    check("rw_data", avs_readdata, 32'h1122CCDD);
    cpu_read("rw_after", 8'd3, 32'h1122CCDD);

    // Collision: CPU read and JTAG read command in the same cycle
    avs_address = 8'd3;
    avs_read    = 1'b1;
    set_cmd(8'd5, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    #1;
    check("col_wait_idle", 32'(avs_waitrequest), 32'd1);
    tick();
    take_action_ocimem_a = 1'b0;
    check("col_wait_jrd", 32'(avs_waitrequest), 32'd1);
    tick();
    check("col_wait_jcap", 32'(avs_waitrequest), 32'd1);
    tick();
    check("col_wait_idle2", 32'(avs_waitrequest), 32'd1);
    check("col_mondreg", MonDReg, 32'h12345678);
    check("col_ready", 32'(monitor_ready), 32'd1);
    tick();
    check("col_wait_crd", 32'(avs_waitrequest), 32'd0);
    avs_read = 1'b0;
    tick();
    check("col_readdata", avs_readdata, 32'h1122CCDD);
    check("col_mondreg_kept", MonDReg, 32'h12345678);
    repeat (2) tick();

    // Reset in the middle of a JTAG read
    set_cmd(8'd5, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    reset_n = 1'b0;
    tick();
    check("mid_rst_mondreg", MonDReg, 32'd0);
    check("mid_rst_ready", 32'(monitor_ready), 32'd0);
    check("mid_rst_wait", 32'(avs_waitrequest), 32'd1);
    reset_n = 1'b1;
    // FSM must be IDLE right away: a CPU write is accepted immediately
    cpu_write("post_rst_idle", 8'd7, 4'hF, 32'h0F0F0F0F, 1'b1);
    cpu_read("post_rst_ram", 8'd5, 32'h12345678);
    cpu_read("post_rst_wr7", 8'd7, 32'h0F0F0F0F);
    check("post_rst_ready", 32'(monitor_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
